// File: rtl/otter_uart_pkg.sv
// Shared definitions for the OTTER memory-mapped UART transmitter:
// FSM states, register offsets, status bit positions and the baud divisor helper.
package otter_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic [31:0] OFF_DATA = 32'd0;
    localparam logic [31:0] OFF_STAT = 32'd4;
    localparam logic [31:0] OFF_CTRL = 32'd8;

    localparam int BUSY  = 0;
    localparam int FULL  = 1;
    localparam int EMPTY = 2;
    localparam int OVF   = 3;

    // Rounded clocks-per-bit; never below 2 so a bit always spans a counter wrap.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + baud / 2) / baud;
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/otter_sync_fifo.sv
// Single-clock FIFO with a combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module otter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/otter_uart_tx.sv
// OTTER IO-bus UART transmitter: DATA/STATUS/CTRL register window, byte FIFO,
// and a baud-timed 8N1 serialiser with a "transmit drained" interrupt pulse.
module otter_uart_tx
    import otter_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        INTR
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(DIV);

    uart_state_t      state;
    uart_state_t      next_state;
    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic             baud_wrap;

    logic             sel_data;
    logic             sel_stat;
    logic             sel_ctrl;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;

    logic             ovf;
    logic             irq_en;
    logic             ovf_set;
    logic             ovf_clr;
    logic             busy;
    logic             tx_next;
    logic             intr_next;
    logic [31:0]      status_word;
    logic [22:0]      unused_bits;

    assign unused_bits = {IOBUS_OUT[31:10], IOBUS_OUT[8]};

    assign sel_data = (IOBUS_ADDR == BASE_ADDR + OFF_DATA);
    assign sel_stat = (IOBUS_ADDR == BASE_ADDR + OFF_STAT);
    assign sel_ctrl = (IOBUS_ADDR == BASE_ADDR + OFF_CTRL);

    assign push      = IOBUS_WR && sel_data;
    assign ovf_set   = push && fifo_full && !pop;
    assign ovf_clr   = IOBUS_WR && sel_stat && IOBUS_OUT[3];
    assign busy      = (state != IDLE);
    assign baud_wrap = (baud_cnt == CNT_W'(DIV - 1));

    otter_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .din   (IOBUS_OUT[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        next_state = state;
        tx_next    = 1'b1;
        intr_next  = 1'b0;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_wrap) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (baud_wrap && bit_idx == 3'd7) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    next_state = IDLE;
                    intr_next  = fifo_empty && irq_en;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // TX and INTR are registered, so the line lags the state by one cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            TX     <= 1'b1;
            INTR   <= 1'b0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            state <= next_state;
            TX    <= tx_next;
            INTR  <= intr_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (IOBUS_WR && sel_ctrl) begin
                irq_en <= IOBUS_OUT[0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (pop) begin
                shift_reg <= fifo_dout;
            end
        end else begin
            baud_cnt <= baud_wrap ? '0 : baud_cnt + CNT_W'(1);
            if (state == DATA && baud_wrap) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        status_word        = '0;
        status_word[BUSY]  = busy;
        status_word[FULL]  = fifo_full;
        status_word[EMPTY] = fifo_empty;
        status_word[OVF]   = ovf;
        IOBUS_IN           = '0;
        if (sel_stat) begin
            IOBUS_IN = status_word;
        end else if (sel_ctrl) begin
            IOBUS_IN = {31'b0, irq_en};
        end
    end

endmodule
